// File: rtl/minus_unit_arbiter_if.sv
// Bus bundle between requesters, the shared subtractor, the result consumer and minus_unit_arbiter.
// MINUS_ARB_BORROW_EN adds io_resp_borrow.
interface minus_unit_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 16,
    parameter int ID_W    = 2
);
    logic [NUM_REQ-1:0]       io_req_valid;
    logic [NUM_REQ-1:0]       io_req_ready;
    logic [NUM_REQ*WIDTH-1:0] io_req_in1;
    logic [NUM_REQ*WIDTH-1:0] io_req_in2;
    logic [WIDTH-1:0]         io_sub_in1;
    logic [WIDTH-1:0]         io_sub_in2;
    logic [WIDTH-1:0]         io_sub_out;
    logic                     io_resp_valid;
    logic                     io_resp_ready;
    logic [WIDTH-1:0]         io_resp_out;
    logic [ID_W-1:0]          io_resp_id;
`ifdef MINUS_ARB_BORROW_EN
    logic                     io_resp_borrow;
`endif

    // master: the client side (requesters, subtractor, consumer)
    modport master (
        output io_req_valid, io_req_in1, io_req_in2, io_sub_out, io_resp_ready,
        input  io_req_ready, io_sub_in1, io_sub_in2, io_resp_valid, io_resp_out, io_resp_id
`ifdef MINUS_ARB_BORROW_EN
      , input  io_resp_borrow
`endif
    );

    modport slave (
        input  io_req_valid, io_req_in1, io_req_in2, io_sub_out, io_resp_ready,
        output io_req_ready, io_sub_in1, io_sub_in2, io_resp_valid, io_resp_out, io_resp_id
`ifdef MINUS_ARB_BORROW_EN
      , output io_resp_borrow
`endif
    );
endinterface

// File: rtl/minus_unit_arbiter.sv
// Round-robin arbiter sharing one combinational subtractor among NUM_REQ requesters.
// Define MINUS_ARB_BORROW_EN to register and expose an unsigned-borrow flag with each result.

module minus_unit_arbiter_lane #(
    parameter int WIDTH = 16
) (
    input  logic             gnt,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic [WIDTH-1:0] sel_in1,
    output logic [WIDTH-1:0] sel_in2
);
    assign sel_in1 = gnt ? in1 : '0;
    assign sel_in2 = gnt ? in2 : '0;
endmodule

module minus_unit_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 16,
    parameter int ID_W    = 2
) (
    input  logic                clock,
    input  logic                reset,
    minus_unit_arbiter_if.slave bus
);
    typedef enum logic {EMPTY, FULL} state_t;

    state_t                           state_q, state_d;
    logic [ID_W-1:0]                  rr_ptr;
    logic [ID_W-1:0]                  gnt_idx;
    logic                             gnt_any;
    logic                             can_issue;
    logic                             grant;
    logic [NUM_REQ-1:0]               gnt_oh;
    logic [NUM_REQ-1:0][WIDTH-1:0]    sel_in1, sel_in2;
    logic [WIDTH-1:0]                 sub_in1, sub_in2;
    logic [WIDTH-1:0]                 resp_out_q;
    logic [ID_W-1:0]                  resp_id_q;

    // First valid requester at or after rr_ptr, wrapping modulo NUM_REQ
    always_comb begin
        logic [ID_W-1:0] idx;
        gnt_any = 1'b0;
        gnt_idx = '0;
        idx     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
            if (!gnt_any && bus.io_req_valid[idx]) begin
                gnt_any = 1'b1;
                gnt_idx = idx;
            end
        end
    end

    // Reset gates issue so no grant leaks out while the block is held in reset
    assign can_issue = !reset && (state_q == EMPTY || bus.io_resp_ready);
    assign grant     = can_issue && gnt_any;

    always_ff @(posedge clock) begin
        if (reset) state_q <= EMPTY;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        gnt_oh  = '0;
        if (grant) begin
            gnt_oh[gnt_idx] = 1'b1;
            state_d         = FULL;
        end else if (state_q == FULL && bus.io_resp_ready) begin
            state_d = EMPTY;
        end
    end

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
        minus_unit_arbiter_lane #(.WIDTH(WIDTH)) u_lane (
            .gnt     (gnt_oh[i]),
            .in1     (bus.io_req_in1[i*WIDTH +: WIDTH]),
            .in2     (bus.io_req_in2[i*WIDTH +: WIDTH]),
            .sel_in1 (sel_in1[i]),
            .sel_in2 (sel_in2[i])
        );
    end

    // Grant is one-hot, so OR-combining the masked lanes is the operand mux
    always_comb begin
        sub_in1 = '0;
        sub_in2 = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            sub_in1 = sub_in1 | sel_in1[i];
            sub_in2 = sub_in2 | sel_in2[i];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rr_ptr     <= '0;
            resp_out_q <= '0;
            resp_id_q  <= '0;
        end else if (grant) begin
            rr_ptr     <= (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + ID_W'(1);
            resp_out_q <= bus.io_sub_out;
            resp_id_q  <= gnt_idx;
        end
    end

`ifdef MINUS_ARB_BORROW_EN
    logic borrow_q;
    always_ff @(posedge clock) begin
        if (reset)      borrow_q <= 1'b0;
        else if (grant) borrow_q <= (sub_in1 < sub_in2);
    end
    assign bus.io_resp_borrow = borrow_q;
`endif

    assign bus.io_req_ready  = gnt_oh;
    assign bus.io_sub_in1    = sub_in1;
    assign bus.io_sub_in2    = sub_in2;
    assign bus.io_resp_valid = (state_q == FULL);
    assign bus.io_resp_out   = resp_out_q;
    assign bus.io_resp_id    = resp_id_q;
endmodule
